// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: default register-file geometry and the
// state encoding of the register-file clear engine.
package cpu_pkg;

  // Default width of one general-purpose register
  localparam int CPU_DATA_W    = 8;
  // Default number of general-purpose registers
  localparam int CPU_REG_DEPTH = 16;

  // Clear engine states
  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

endpackage : cpu_pkg

// File: rtl/reg_clear_ctrl.sv
// Clear sequencer for the register file. It walks a pointer over every entry
// and requests a zero write for each one. It runs after reset and whenever clr
// is pulsed. While it runs, busy is high and the register file rejects user
// accesses.
module reg_clear_ctrl
  import cpu_pkg::*;
#(
  parameter  int DEPTH  = CPU_REG_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

  rf_state_t         r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_busy;

  rf_state_t         w_state_nxt;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic              w_busy_nxt;

  // Next-state logic: clr restarts the walk; the last entry exits to idle
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_busy_nxt  = r_busy;
    case (r_state)
      RF_IDLE: begin
        if (clr) begin
          w_state_nxt = RF_CLEAR;
          w_ptr_nxt   = ZERO_ADDR;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = RF_IDLE;
          w_ptr_nxt   = r_ptr;
          w_busy_nxt  = 1'b0;
        end
      end
      RF_CLEAR: begin
        if (clr) begin
          // Restart from the first entry; DEPTH more cycles follow.
          w_state_nxt = RF_CLEAR;
          w_ptr_nxt   = ZERO_ADDR;
          w_busy_nxt  = 1'b1;
        end else if (r_ptr == LAST_ADDR) begin
          // The last entry is cleared on this edge; the pointer never wraps.
          w_state_nxt = RF_IDLE;
          w_ptr_nxt   = ZERO_ADDR;
          w_busy_nxt  = 1'b0;
        end else begin
          w_state_nxt = RF_CLEAR;
          w_ptr_nxt   = r_ptr + ONE_ADDR;
          w_busy_nxt  = 1'b1;
        end
      end
      default: begin
        // An illegal encoding is recovered by running a fresh clear.
        w_state_nxt = RF_CLEAR;
        w_ptr_nxt   = ZERO_ADDR;
        w_busy_nxt  = 1'b1;
      end
    endcase
  end

  // State, pointer and busy registers; reset takes priority over clr
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RF_CLEAR;
      r_ptr   <= ZERO_ADDR;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // busy is high exactly while in CLEAR, so it also enables the zero write.
  assign clr_we   = r_busy;
  assign clr_addr = r_ptr;
  assign busy     = r_busy;

endmodule : reg_clear_ctrl

// File: rtl/reg_file_mp.sv
// General-purpose register file for the 8-bit CPU datapath. It has one write
// port and two independent registered read ports. A read of the address being
// written in the same cycle returns the new data (write-first). A clear engine
// zeroes all entries after reset and on request.
module reg_file_mp
  import cpu_pkg::*;
#(
  parameter  int DATA_W = CPU_DATA_W,
  parameter  int DEPTH  = CPU_REG_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              write,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              read_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic              read_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_valid_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid_b,
  output logic              busy
);

  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

  // Storage is not reset directly; the clear engine zeroes it after reset.
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DATA_W-1:0] r_rd_data_a;
  logic              r_rd_valid_a;
  logic [DATA_W-1:0] r_rd_data_b;
  logic              r_rd_valid_b;

  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_busy;

  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;

  logic [DATA_W-1:0] w_rd_next_a;
  logic [DATA_W-1:0] w_rd_next_b;

  reg_clear_ctrl #(
    .DEPTH (DEPTH)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr),
    .busy     (w_busy)
  );

  // Write mux: the clear engine owns the write port while busy
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = wr_addr;
    w_mem_data = wr_data;
    if (w_clr_we) begin
      w_mem_we   = 1'b1;
      w_mem_addr = w_clr_addr;
      w_mem_data = ZERO_DATA;
    end else begin
      w_mem_we   = write;
      w_mem_addr = wr_addr;
      w_mem_data = wr_data;
    end
  end

  // Storage array update
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  // Read-data selection per port, forwarding same-cycle write data
  always_comb begin
    w_rd_next_a = r_mem[rd_addr_a];
    w_rd_next_b = r_mem[rd_addr_b];
    if (write && (wr_addr == rd_addr_a)) begin
      w_rd_next_a = wr_data;
    end else begin
      w_rd_next_a = r_mem[rd_addr_a];
    end
    if (write && (wr_addr == rd_addr_b)) begin
      w_rd_next_b = wr_data;
    end else begin
      w_rd_next_b = r_mem[rd_addr_b];
    end
  end

  // Port A output register: zeroed while busy, held when idle with no request
  always_ff @(posedge clk) begin
    if (rst || w_busy) begin
      r_rd_data_a  <= ZERO_DATA;
      r_rd_valid_a <= 1'b0;
    end else if (read_a) begin
      r_rd_data_a  <= w_rd_next_a;
      r_rd_valid_a <= 1'b1;
    end else begin
      r_rd_data_a  <= r_rd_data_a;
      r_rd_valid_a <= 1'b0;
    end
  end

  // Port B output register: zeroed while busy, held when idle with no request
  always_ff @(posedge clk) begin
    if (rst || w_busy) begin
      r_rd_data_b  <= ZERO_DATA;
      r_rd_valid_b <= 1'b0;
    end else if (read_b) begin
      r_rd_data_b  <= w_rd_next_b;
      r_rd_valid_b <= 1'b1;
    end else begin
      r_rd_data_b  <= r_rd_data_b;
      r_rd_valid_b <= 1'b0;
    end
  end

  assign rd_data_a  = r_rd_data_a;
  assign rd_valid_a = r_rd_valid_a;
  assign rd_data_b  = r_rd_data_b;
  assign rd_valid_b = r_rd_valid_b;
  assign busy       = w_busy;

endmodule : reg_file_mp

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (DATA_W=8, DEPTH=16).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
`timescale 1ns/1ps
module tb_reg_file_mp;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       write;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       read_a;
  logic [3:0] rd_addr_a;
  logic       read_b;
  logic [3:0] rd_addr_b;
  logic [7:0] rd_data_a;
  logic       rd_valid_a;
  logic [7:0] rd_data_b;
  logic       rd_valid_b;
  logic       busy;

  int checks = 0;
  int errors = 0;

  reg_file_mp dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .write      (write),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .read_a     (read_a),
    .rd_addr_a  (rd_addr_a),
    .read_b     (read_b),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_valid_a (rd_valid_a),
    .rd_data_b  (rd_data_b),
    .rd_valid_b (rd_valid_b),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 1'b0; write = 1'b0; read_a = 1'b0; read_b = 1'b0;
  endtask

  // Count busy samples, starting at the current one, until busy falls.
  task automatic count_busy(output int cnt);
    int guard;
    cnt = 0;
    guard = 0;
    while (busy === 1'b1 && guard < 60) begin
      cnt++;
      guard++;
      tick();
    end
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b1;
    idle_inputs();
    wr_addr = 4'd0; wr_data = 8'h00; rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b1 || rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0 ||
        rd_data_a !== 8'h00 || rd_data_b !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: busy=%b va=%b vb=%b da=%h db=%h, required busy=1 va=0 vb=0 da=00 db=00",
               busy, rd_valid_a, rd_valid_b, rd_data_a, rd_data_b);
    end
    count_busy(cnt);
    checks++;
    if (cnt !== 16) begin
      errors++;
      $display("FAIL reset_busy_len: got %0d cycles, required 16", cnt);
    end
    for (int i = 0; i < 16; i++) begin
      read_a = 1'b1;
      rd_addr_a = 4'(i);
      tick();
      checks++;
      if (rd_data_a !== 8'h00 || rd_valid_a !== 1'b1) begin
        errors++;
        $display("FAIL reset_clear_rd addr %0d: data=%h valid=%b, required 00 valid=1",
                 i, rd_data_a, rd_valid_a);
      end
    end
    read_a = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    write = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
    tick();
    write = 1'b0;
    read_a = 1'b1; rd_addr_a = 4'd3;
    tick();
    checks++;
    if (rd_data_a !== 8'hA5 || rd_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL wr_rd: data=%h valid=%b, required A5 valid=1", rd_data_a, rd_valid_a);
    end
    read_a = 1'b0;
    tick();
    checks++;
    if (rd_data_a !== 8'hA5 || rd_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL rd_hold: data=%h valid=%b, required A5 valid=0", rd_data_a, rd_valid_a);
    end
  endtask

  task automatic test_forward();
    write = 1'b1; wr_addr = 4'd7; wr_data = 8'h3C;
    read_a = 1'b1; rd_addr_a = 4'd7;
    read_b = 1'b1; rd_addr_b = 4'd7;
    tick();
    write = 1'b0; read_b = 1'b0;
    checks++;
    if (rd_data_a !== 8'h3C || rd_valid_a !== 1'b1 ||
        rd_data_b !== 8'h3C || rd_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL forward: da=%h va=%b db=%h vb=%b, required 3C/1 3C/1",
               rd_data_a, rd_valid_a, rd_data_b, rd_valid_b);
    end
    rd_addr_a = 4'd7;
    tick();
    checks++;
    if (rd_data_a !== 8'h3C || rd_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL forward_stored: data=%h valid=%b, required 3C valid=1", rd_data_a, rd_valid_a);
    end
    read_a = 1'b0;
    tick();
  endtask

  task automatic test_dual_port();
    write = 1'b1; wr_addr = 4'd2; wr_data = 8'h11;
    tick();
    wr_addr = 4'd9; wr_data = 8'h99;
    tick();
    write = 1'b0;
    read_a = 1'b1; rd_addr_a = 4'd2;
    read_b = 1'b1; rd_addr_b = 4'd9;
    tick();
    checks++;
    if (rd_data_a !== 8'h11 || rd_valid_a !== 1'b1 ||
        rd_data_b !== 8'h99 || rd_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL dual_port: da=%h va=%b db=%h vb=%b, required 11/1 99/1",
               rd_data_a, rd_valid_a, rd_data_b, rd_valid_b);
    end
    rd_addr_a = 4'd9; rd_addr_b = 4'd2;
    tick();
    checks++;
    if (rd_data_a !== 8'h99 || rd_data_b !== 8'h11) begin
      errors++;
      $display("FAIL dual_port_swap: da=%h db=%h, required 99 11", rd_data_a, rd_data_b);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_clear_blocks();
    int cnt;
    int bad_valid;
    int guard;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    write = 1'b1; wr_addr = 4'd5; wr_data = 8'hFF;
    read_a = 1'b1; rd_addr_a = 4'd5;
    cnt = 0; bad_valid = 0; guard = 0;
    while (busy === 1'b1 && guard < 60) begin
      cnt++;
      guard++;
      tick();
      if (busy === 1'b1 && (rd_valid_a !== 1'b0 || rd_data_a !== 8'h00)) bad_valid++;
    end
    checks++;
    if (cnt !== 16) begin
      errors++;
      $display("FAIL clr_busy_len: got %0d cycles, required 16", cnt);
    end
    checks++;
    if (bad_valid !== 0) begin
      errors++;
      $display("FAIL busy_read_blocked: %0d cycles with valid/data set, required 0", bad_valid);
    end
    write = 1'b0;
    rd_addr_a = 4'd5;
    read_b = 1'b1; rd_addr_b = 4'd3;
    tick();
    checks++;
    if (rd_data_a !== 8'h00 || rd_valid_a !== 1'b1 || rd_data_b !== 8'h00) begin
      errors++;
      $display("FAIL busy_write_dropped: a5=%h va=%b a3=%h, required 00 valid=1 00",
               rd_data_a, rd_valid_a, rd_data_b);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_clr_restart();
    int cnt;
    int guard;
    int nonzero;
    write = 1'b1; wr_addr = 4'd12; wr_data = 8'h5A;
    tick();
    wr_addr = 4'd0; wr_data = 8'h77;
    tick();
    write = 1'b0;
    clr = 1'b1;
    tick();
    cnt = 0; guard = 0;
    while (busy === 1'b1 && guard < 60) begin
      cnt++;
      guard++;
      clr = (cnt == 5) ? 1'b1 : 1'b0;
      tick();
    end
    clr = 1'b0;
    checks++;
    if (cnt !== 21) begin
      errors++;
      $display("FAIL clr_restart_len: got %0d cycles, required 21", cnt);
    end
    nonzero = 0;
    for (int i = 0; i < 16; i++) begin
      read_b = 1'b1;
      rd_addr_b = 4'(i);
      tick();
      if (rd_data_b !== 8'h00 || rd_valid_b !== 1'b1) nonzero++;
    end
    read_b = 1'b0;
    checks++;
    if (nonzero !== 0) begin
      errors++;
      $display("FAIL clr_restart_zero: %0d entries not zero/valid, required 0", nonzero);
    end
    tick();
  endtask

  task automatic test_rst_midclear();
    int cnt;
    write = 1'b1; wr_addr = 4'd14; wr_data = 8'hC3;
    tick();
    write = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; clr = 1'b1;
    tick();
    rst = 1'b0; clr = 1'b0;
    count_busy(cnt);
    checks++;
    if (cnt !== 16) begin
      errors++;
      $display("FAIL rst_midclear_len: got %0d cycles, required 16", cnt);
    end
    read_a = 1'b1; rd_addr_a = 4'd14;
    tick();
    read_a = 1'b0;
    checks++;
    if (rd_data_a !== 8'h00 || rd_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL rst_midclear_zero: data=%h valid=%b, required 00 valid=1", rd_data_a, rd_valid_a);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_forward();
    test_dual_port();
    test_clear_blocks();
    test_clr_restart();
    test_rst_midclear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_reg_file_mp
